fft_frame_sequencer: RTL and testbench

// - Sequences the mono sample stream into fixed-length frames on the FFT core's Avalon-ST sink.
// - Generates the FFT core reset, sop/eop framing and valid, and honours sink_ready backpressure through a small FIFO.
// - Optionally holds each new frame until the FFT has emitted the previous result.
// - Sits between the audio sample source and the FFT core; replaces free-running framing logic.

---
 rtl/fft_ctrl_pkg.sv | 23 ++
 rtl/fft_sample_fifo.sv | 48 ++++
 rtl/fft_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer and its sample FIFO.
package fft_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    S_FFT_RST  = 2'd0,
    S_IDLE     = 2'd1,
    S_STREAM   = 2'd2,
    S_WAIT_OUT = 2'd3
  } state_t;

  localparam int N_POINTS_DEF   = 8192;
  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int RST_CYCLES_DEF = 3;
  localparam int FRAME_CNT_W    = 16;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_sample_fifo.sv
// Synchronous sample FIFO with a show-ahead head. A push while full is taken
// only when a pop happens in the same cycle; pops while empty are ignored.
module fft_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames the mono sample stream onto the FFT Avalon-ST sink: drives the FFT
// core reset, sop/eop/valid, honours sink_ready through a small FIFO and can
// hold each new frame until the FFT has emitted the previous result.
//
// state      | meaning
// S_FFT_RST  | holding fft_reset_n low for RST_CYCLES cycles
// S_IDLE     | FFT ready, waiting for enable
// S_STREAM   | transferring FIFO samples to the FFT sink
// S_WAIT_OUT | frame sent, waiting for the FFT source eop
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N_POINTS    = N_POINTS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter bit WAIT_SOURCE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DATA_W-1:0]      sample_in,
  input  logic                   sample_valid,
  input  logic                   sink_ready,
  input  logic                   source_valid,
  input  logic                   source_eop,
  output logic                   fft_reset_n,
  output logic                   sink_valid,
  output logic                   sink_sop,
  output logic                   sink_eop,
  output logic [DATA_W-1:0]      sink_real,
  output logic [DATA_W-1:0]      sink_imag,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overflow
);

  localparam int PT_W = $clog2(N_POINTS);
  localparam int RC_W = cnt_width(RST_CYCLES);

  state_t                   state;
  state_t                   state_next;
  logic [RC_W-1:0]          rst_cnt;
  logic [PT_W-1:0]          pt_cnt;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q;
  logic                     frame_done_q;
  logic                     overflow_q;

  logic                     push_req;
  logic                     xfer;
  logic                     last_pt;
  logic                     eop_xfer;
  logic                     rst_done;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [DATA_W-1:0]        fifo_head;

  assign push_req = sample_valid & enable & (state != S_FFT_RST);
  assign last_pt  = (pt_cnt == PT_W'(N_POINTS - 1));
  assign xfer     = sink_valid & sink_ready;
  assign eop_xfer = xfer & last_pt;
  assign rst_done = (rst_cnt == '0);

  assign fft_reset_n = (state != S_FFT_RST);
  assign sink_valid  = (state == S_STREAM) & ~fifo_empty;
  assign sink_sop    = sink_valid & (pt_cnt == '0);
  assign sink_eop    = sink_valid & last_pt;
  // Head is masked while invalid so stale FIFO storage never reaches the pins.
  assign sink_real   = sink_valid ? fifo_head : '0;
  assign sink_imag   = '0;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_cnt_q;
  assign overflow    = overflow_q;

  fft_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (xfer),
    .din     (sample_in),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FFT_RST;
    else          state <= state_next;
  end

  // Next-state logic; a frame in progress always runs to its eop.
  always_comb begin
    state_next = state;
    case (state)
      S_FFT_RST: begin
        if (rst_done) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (enable) state_next = S_STREAM;
      end
      S_STREAM: begin
        if (eop_xfer) begin
          if (WAIT_SOURCE)  state_next = S_WAIT_OUT;
          else if (!enable) state_next = S_IDLE;
        end
      end
      S_WAIT_OUT: begin
        if (source_valid && source_eop) state_next = enable ? S_STREAM : S_IDLE;
      end
      default: state_next = S_FFT_RST;
    endcase
  end

  // FFT reset timer: down-counter loaded at reset, terminal count at zero.
  always_ff @(posedge clk) begin
    if (!reset_n)                              rst_cnt <= RC_W'(RST_CYCLES - 1);
    else if (state == S_FFT_RST && !rst_done)  rst_cnt <= rst_cnt - 1'b1;
  end

  // Point counter: position of the FIFO head within the current frame.
  always_ff @(posedge clk) begin
    if (!reset_n)   pt_cnt <= '0;
    else if (xfer)  pt_cnt <= last_pt ? '0 : pt_cnt + 1'b1;
  end

  // Frame completion pulse and wrapping frame counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= eop_xfer;
      if (eop_xfer) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Sticky overflow: a sample offered to a full FIFO with no pop is lost.
  always_ff @(posedge clk) begin
    if (!reset_n)                                overflow_q <= 1'b0;
    else if (push_req && fifo_full && !xfer)     overflow_q <= 1'b1;
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with N_POINTS=8, FIFO_DEPTH=4,
// RST_CYCLES=3, WAIT_SOURCE=1. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sink_ready;
  logic        source_valid;
  logic        source_eop;
  logic        fft_reset_n;
  logic        sink_valid;
  logic        sink_sop;
  logic        sink_eop;
  logic [15:0] sink_real;
  logic [15:0] sink_imag;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .N_POINTS    (8),
    .DATA_W      (16),
    .FIFO_DEPTH  (4),
    .RST_CYCLES  (3),
    .WAIT_SOURCE (1'b1)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sink_ready   (sink_ready),
    .source_valid (source_valid),
    .source_eop   (source_eop),
    .fft_reset_n  (fft_reset_n),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sink_chk(input string tag, input logic v, input logic [15:0] r,
                          input logic sop, input logic eop);
    chk({tag, ".valid"}, 32'(sink_valid), 32'(v));
    chk({tag, ".real"},  32'(sink_real),  32'(r));
    chk({tag, ".sop"},   32'(sink_sop),   32'(sop));
    chk({tag, ".eop"},   32'(sink_eop),   32'(eop));
  endtask

  // One cycle of stimulus, then move to the sampling point.
  task automatic step(input logic sv, input logic [15:0] s, input logic rdy,
                      input logic en, input logic src);
    @(posedge clk);
    #1;
    sample_valid = sv;
    sample_in    = s;
    sink_ready   = rdy;
    enable       = en;
    source_valid = src;
    source_eop   = src;
    @(negedge clk);
  endtask

  task automatic wait_fft_rst_release(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!fft_reset_n && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!fft_reset_n) chk({tag, ".release_timeout"}, 32'(fft_reset_n), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    enable       = 1'b0;
    sink_ready   = 1'b0;
    source_valid = 1'b0;
    source_eop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_fft_rst_release(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    logic sv_seen;

    reset_n      = 1'b0;
    enable       = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    sink_ready   = 1'b0;
    source_valid = 1'b0;
    source_eop   = 1'b0;

    // ---- reset state and FFT reset length
    @(posedge clk);
    @(negedge clk);
    chk("rst.fft_reset_n", 32'(fft_reset_n), 32'd0);
    sink_chk("rst", 1'b0, 16'd0, 1'b0, 1'b0);
    chk("rst.imag",        32'(sink_imag),   32'd0);
    chk("rst.frame_done",  32'(frame_done),  32'd0);
    chk("rst.frame_count", 32'(frame_count), 32'd0);
    chk("rst.overflow",    32'(overflow),    32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    low_cnt = 0;
    sv_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sink_valid) sv_seen = 1'b1;
      if (fft_reset_n) break;
      low_cnt++;
    end
    chk("rst.low_cycles", 32'(low_cnt), 32'd3);
    chk("rst.released",   32'(fft_reset_n), 32'd1);
    chk("rst.no_valid",   32'(sv_seen), 32'd0);

    // ---- full frame, samples 1..8, sink always ready
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 16'(k), 1'b1, 1'b1, 1'b0);
      if (k == 1) sink_chk("t2.s1", 1'b0, 16'd0, 1'b0, 1'b0);
      else        sink_chk("t2.s", 1'b1, 16'(k - 1), k == 2, 1'b0);
      chk("t2.done_early", 32'(frame_done), 32'd0);
    end
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    sink_chk("t2.s8", 1'b1, 16'd8, 1'b0, 1'b1);
    chk("t2.done_at_eop", 32'(frame_done), 32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t2.frame_done",  32'(frame_done),  32'd1);
    chk("t2.frame_count", 32'(frame_count), 32'd1);
    chk("t2.valid_wait",  32'(sink_valid),  32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t2.done_once",   32'(frame_done),  32'd0);

    // ---- WAIT_SOURCE: next frame held until source eop
    step(1'b1, 16'd11, 1'b1, 1'b1, 1'b0);
    chk("t3.hold0", 32'(sink_valid), 32'd0);
    step(1'b1, 16'd12, 1'b1, 1'b1, 1'b0);
    chk("t3.hold1", 32'(sink_valid), 32'd0);
    step(1'b1, 16'd13, 1'b1, 1'b1, 1'b0);
    sink_chk("t3.hold2", 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
    chk("t3.hold_src", 32'(sink_valid), 32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    sink_chk("t3.release", 1'b1, 16'd11, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    sink_chk("t3.next", 1'b1, 16'd12, 1'b0, 1'b0);

    // ---- backpressure on sample 4 for 5 cycles, then overflow at depth 4
    do_reset("t4");
    step(1'b1, 16'd1, 1'b1, 1'b1, 1'b0); sink_chk("t4.1", 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd2, 1'b1, 1'b1, 1'b0); sink_chk("t4.2", 1'b1, 16'd1, 1'b1, 1'b0);
    step(1'b1, 16'd3, 1'b1, 1'b1, 1'b0); sink_chk("t4.3", 1'b1, 16'd2, 1'b0, 1'b0);
    step(1'b1, 16'd4, 1'b1, 1'b1, 1'b0); sink_chk("t4.4", 1'b1, 16'd3, 1'b0, 1'b0);
    step(1'b1, 16'd5, 1'b0, 1'b1, 1'b0); sink_chk("t4.stall1", 1'b1, 16'd4, 1'b0, 1'b0);
    step(1'b1, 16'd6, 1'b0, 1'b1, 1'b0); sink_chk("t4.stall2", 1'b1, 16'd4, 1'b0, 1'b0);
    step(1'b1, 16'd7, 1'b0, 1'b1, 1'b0); sink_chk("t4.stall3", 1'b1, 16'd4, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); sink_chk("t4.stall4", 1'b1, 16'd4, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); sink_chk("t4.stall5", 1'b1, 16'd4, 1'b0, 1'b0);
    chk("t4.no_ovf_full", 32'(overflow), 32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0); sink_chk("t4.resume", 1'b1, 16'd4, 1'b0, 1'b0);
    step(1'b1, 16'd8, 1'b1, 1'b1, 1'b0); sink_chk("t4.5", 1'b1, 16'd5, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0); sink_chk("t4.6", 1'b1, 16'd6, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0); sink_chk("t4.7", 1'b1, 16'd7, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0); sink_chk("t4.8", 1'b1, 16'd8, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t4.frame_done",  32'(frame_done),  32'd1);
    chk("t4.frame_count", 32'(frame_count), 32'd1);
    chk("t4.no_ovf",      32'(overflow),    32'd0);
    // Waiting for source eop: nothing pops, four samples fill the FIFO.
    step(1'b1, 16'd21, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd22, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd23, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd24, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd25, 1'b1, 1'b1, 1'b0);
    chk("t4.ovf_at_4", 32'(overflow), 32'd0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
    chk("t4.ovf_at_5", 32'(overflow), 32'd1);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    sink_chk("t4.f2_first", 1'b1, 16'd21, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    sink_chk("t4.f2_second", 1'b1, 16'd22, 1'b0, 1'b0);
    chk("t4.ovf_sticky", 32'(overflow), 32'd1);

    // ---- enable dropped after sample 5, frame completes later
    do_reset("t5");
    step(1'b1, 16'd1, 1'b1, 1'b1, 1'b0);  sink_chk("t5.1", 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd2, 1'b1, 1'b1, 1'b0);  sink_chk("t5.2", 1'b1, 16'd1, 1'b1, 1'b0);
    step(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);  sink_chk("t5.3", 1'b1, 16'd2, 1'b0, 1'b0);
    step(1'b1, 16'd4, 1'b1, 1'b1, 1'b0);  sink_chk("t5.4", 1'b1, 16'd3, 1'b0, 1'b0);
    step(1'b1, 16'd5, 1'b1, 1'b1, 1'b0);  sink_chk("t5.5", 1'b1, 16'd4, 1'b0, 1'b0);
    step(1'b1, 16'd99, 1'b1, 1'b0, 1'b0); sink_chk("t5.6", 1'b1, 16'd5, 1'b0, 1'b0);
    step(1'b1, 16'd98, 1'b1, 1'b0, 1'b0); sink_chk("t5.gap1", 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);  sink_chk("t5.gap2", 1'b0, 16'd0, 1'b0, 1'b0);
    chk("t5.no_ovf",   32'(overflow),   32'd0);
    chk("t5.not_done", 32'(frame_count), 32'd0);
    step(1'b1, 16'd6, 1'b1, 1'b1, 1'b0);  sink_chk("t5.gap3", 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd7, 1'b1, 1'b1, 1'b0);  sink_chk("t5.s6", 1'b1, 16'd6, 1'b0, 1'b0);
    step(1'b1, 16'd8, 1'b1, 1'b1, 1'b0);  sink_chk("t5.s7", 1'b1, 16'd7, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);  sink_chk("t5.s8", 1'b1, 16'd8, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    chk("t5.frame_done",  32'(frame_done),  32'd1);
    chk("t5.frame_count", 32'(frame_count), 32'd1);

    // ---- reset mid-frame at pt_cnt=3
    do_reset("t6");
    step(1'b1, 16'd1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd4, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
    sink_chk("t6.pre", 1'b1, 16'd4, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    sink_chk("t6.rst", 1'b0, 16'd0, 1'b0, 1'b0);
    chk("t6.fft_reset_n", 32'(fft_reset_n), 32'd0);
    chk("t6.frame_done",  32'(frame_done),  32'd0);
    chk("t6.frame_count", 32'(frame_count), 32'd0);
    chk("t6.overflow",    32'(overflow),    32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b0;
    wait_fft_rst_release("t6");
    step(1'b1, 16'd10, 1'b1, 1'b1, 1'b0); sink_chk("t6.empty", 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd11, 1'b1, 1'b1, 1'b0); sink_chk("t6.sop", 1'b1, 16'd10, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);  sink_chk("t6.next", 1'b1, 16'd11, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
